// File: rtl/genesys_imem_pkg.sv
// Shared definitions for the instruction fetch path: FSM encoding and
// block / instruction sizing helpers.
package genesys_imem_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      FETCH = 3'd3,
      DRAIN = 3'd4
   } fetch_state_e;

   localparam int DEF_INST_DATA_WIDTH = 32;
   localparam int DEF_INST_ADDR_WIDTH = 10;
   localparam int BLOCK_INST          = 2 ** DEF_INST_ADDR_WIDTH;
   localparam int BYTES_PER_INST      = DEF_INST_DATA_WIDTH / 8;

   function automatic int block_inst(input int addr_w);
      return 1 << addr_w;
   endfunction

   function automatic int bytes_per_inst(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/fetch_inst_fifo.sv
// Output instruction FIFO carrying {last, data}; push and pop may coincide at
// any occupancy. Head outputs read zero while empty.
module fetch_inst_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push_i,
   input  logic [W-1:0]  push_data_i,
   input  logic          push_last_i,
   input  logic          pop_i,
   output logic          valid_o,
   output logic [W-1:0]  data_o,
   output logic          last_o,
   output logic [CW-1:0] count_o
);
   localparam int PW = $clog2(DEPTH);

   logic [W:0]    mem_q [DEPTH];
   logic [PW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push, do_pop;

   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= {push_last_i, push_data_i};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   assign valid_o = (count_q != '0);
   assign data_o  = valid_o ? mem_q[rd_ptr_q][W-1:0] : '0;
   assign last_o  = valid_o ? mem_q[rd_ptr_q][W] : 1'b0;
   assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetches a program block by block: requests a DDR load, waits for the
// instruction memory to fill, streams the block through a credit-limited FIFO.
module instruction_fetch_unit
   import genesys_imem_pkg::*;
#(
   parameter int INST_DATA_WIDTH = 32,
   parameter int INST_ADDR_WIDTH = 10,
   parameter int AXI_ADDR_WIDTH  = 42,
   parameter int MEM_REQ_W       = 16,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [AXI_ADDR_WIDTH-1:0]  cfg_base_addr,
   input  logic [31:0]                cfg_num_inst,
   input  logic                       imem_block_ready,
   output logic                       imem_rd_req,
   output logic [INST_ADDR_WIDTH-1:0] imem_rd_addr,
   input  logic                       imem_rd_valid,
   input  logic [INST_DATA_WIDTH-1:0] imem_rd_data,
   output logic                       imem_rd_block_done,
   output logic [AXI_ADDR_WIDTH-1:0]  decoder_ld_addr,
   output logic [MEM_REQ_W-1:0]       decoder_ld_req_size,
   output logic                       decoder_ld_req_in,
   output logic                       inst_valid,
   input  logic                       inst_ready,
   output logic [INST_DATA_WIDTH-1:0] inst_data,
   output logic                       inst_last,
   output logic                       busy
);
   localparam int BLK_INST = block_inst(INST_ADDR_WIDTH);
   localparam int BPI      = bytes_per_inst(INST_DATA_WIDTH);
   localparam int CNT_W    = INST_ADDR_WIDTH + 1;
   localparam int FCW      = $clog2(FIFO_DEPTH + 1);

   fetch_state_e              state_q, state_d;
   logic [AXI_ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d, ld_addr_q, ld_addr_d;
   logic [MEM_REQ_W-1:0]      ld_size_q, ld_size_d;
   logic                      ld_tog_q, ld_tog_d;
   logic [31:0]               remaining_q, remaining_d, total_q, total_d;
   logic [31:0]               push_idx_q, push_idx_d;
   logic [CNT_W-1:0]          blk_n_q, blk_n_d, issued_q, issued_d;
   logic [CNT_W-1:0]          returned_q, returned_d, blk_n_calc;
   logic                      outstanding_q, rdy_prev_q;

   logic [FCW-1:0]            fifo_count;
   logic                      push, pop, rd_req, blk_done, fifo_empty_nxt;

   assign pop  = inst_valid && inst_ready;
   // Only reads issued by the live program land in the FIFO; a return that
   // arrives just after reset finds outstanding_q cleared and is dropped.
   assign push = imem_rd_valid && outstanding_q;

   assign rd_req = (state_q == FETCH) && (issued_q < blk_n_q) &&
                   ((32'(fifo_count) + 32'(outstanding_q)) < FIFO_DEPTH);
   assign blk_done       = (state_q == FETCH) && (returned_q == blk_n_q);
   assign fifo_empty_nxt = (fifo_count == '0) || ((fifo_count == FCW'(1)) && pop);
   assign blk_n_calc     = (remaining_q > 32'(BLK_INST)) ? CNT_W'(BLK_INST)
                                                         : CNT_W'(remaining_q);

   always_comb begin
      state_d     = state_q;
      cur_addr_d  = cur_addr_q;
      ld_addr_d   = ld_addr_q;
      ld_size_d   = ld_size_q;
      ld_tog_d    = ld_tog_q;
      remaining_d = remaining_q;
      total_d     = total_q;
      push_idx_d  = push ? push_idx_q + 32'd1 : push_idx_q;
      blk_n_d     = blk_n_q;
      issued_d    = rd_req ? issued_q + 1'b1 : issued_q;
      returned_d  = push ? returned_q + 1'b1 : returned_q;
      case (state_q)
         IDLE: begin
            if (start && (cfg_num_inst != 32'd0)) begin
               cur_addr_d  = cfg_base_addr;
               remaining_d = cfg_num_inst;
               total_d     = cfg_num_inst;
               push_idx_d  = 32'd0;
               state_d     = REQ;
            end
         end
         REQ: begin
            blk_n_d   = blk_n_calc;
            ld_addr_d = cur_addr_q;
            ld_size_d = MEM_REQ_W'(32'(blk_n_calc) * 32'(BPI));
            ld_tog_d  = ~ld_tog_q;
            state_d   = WAIT;
         end
         WAIT: begin
            if (imem_block_ready && !rdy_prev_q) begin
               issued_d   = '0;
               returned_d = '0;
               state_d    = FETCH;
            end
         end
         FETCH: begin
            if (blk_done) begin
               cur_addr_d  = cur_addr_q + AXI_ADDR_WIDTH'(blk_n_q) * AXI_ADDR_WIDTH'(BPI);
               remaining_d = remaining_q - 32'(blk_n_q);
               if (remaining_q != 32'(blk_n_q)) state_d = REQ;
               else                             state_d = fifo_empty_nxt ? IDLE : DRAIN;
            end
         end
         DRAIN: begin
            if (fifo_empty_nxt) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         cur_addr_q    <= '0;
         ld_addr_q     <= '0;
         ld_size_q     <= '0;
         ld_tog_q      <= 1'b0;
         remaining_q   <= '0;
         total_q       <= '0;
         push_idx_q    <= '0;
         blk_n_q       <= '0;
         issued_q      <= '0;
         returned_q    <= '0;
         outstanding_q <= 1'b0;
         rdy_prev_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         cur_addr_q    <= cur_addr_d;
         ld_addr_q     <= ld_addr_d;
         ld_size_q     <= ld_size_d;
         ld_tog_q      <= ld_tog_d;
         remaining_q   <= remaining_d;
         total_q       <= total_d;
         push_idx_q    <= push_idx_d;
         blk_n_q       <= blk_n_d;
         issued_q      <= issued_d;
         returned_q    <= returned_d;
         outstanding_q <= rd_req;
         rdy_prev_q    <= imem_block_ready;
      end
   end

   fetch_inst_fifo #(
      .W     (INST_DATA_WIDTH),
      .DEPTH (FIFO_DEPTH),
      .CW    (FCW)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (push),
      .push_data_i (imem_rd_data),
      .push_last_i (push_idx_q == total_q - 32'd1),
      .pop_i       (pop),
      .valid_o     (inst_valid),
      .data_o      (inst_data),
      .last_o      (inst_last),
      .count_o     (fifo_count)
   );

   assign imem_rd_req         = rd_req;
   assign imem_rd_addr        = issued_q[INST_ADDR_WIDTH-1:0];
   assign imem_rd_block_done  = blk_done;
   assign decoder_ld_addr     = ld_addr_q;
   assign decoder_ld_req_size = ld_size_q;
   assign decoder_ld_req_in   = ld_tog_q;
   assign busy                = (state_q != IDLE);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench: DDR/imem model returns word address as data, so every
// delivered instruction must equal base/4 + global index.
module tb_instruction_fetch_unit;
   localparam int DW = 32, IAW = 10, AW = 42, MW = 16, FD = 4;

   logic          clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic [AW-1:0] cfg_base_addr = '0;
   logic [31:0]   cfg_num_inst = '0;
   logic          imem_block_ready = 1'b0, imem_rd_valid = 1'b0;
   logic [DW-1:0] imem_rd_data = '0;
   logic          inst_ready = 1'b1;
   logic          imem_rd_req, imem_rd_block_done, decoder_ld_req_in;
   logic [IAW-1:0] imem_rd_addr;
   logic [AW-1:0] decoder_ld_addr;
   logic [MW-1:0] decoder_ld_req_size;
   logic          inst_valid, inst_last, busy;
   logic [DW-1:0] inst_data;

   int nvec = 0, nmis = 0;

   instruction_fetch_unit #(
      .INST_DATA_WIDTH(DW), .INST_ADDR_WIDTH(IAW), .AXI_ADDR_WIDTH(AW),
      .MEM_REQ_W(MW), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .cfg_base_addr(cfg_base_addr),
      .cfg_num_inst(cfg_num_inst), .imem_block_ready(imem_block_ready),
      .imem_rd_req(imem_rd_req), .imem_rd_addr(imem_rd_addr),
      .imem_rd_valid(imem_rd_valid), .imem_rd_data(imem_rd_data),
      .imem_rd_block_done(imem_rd_block_done), .decoder_ld_addr(decoder_ld_addr),
      .decoder_ld_req_size(decoder_ld_req_size), .decoder_ld_req_in(decoder_ld_req_in),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
      .inst_last(inst_last), .busy(busy)
   );

   always #5 clk = ~clk;

   // Memory model: one-cycle read latency, block fills 3 cycles after a toggle.
   logic tog_prev = 1'b0;
   int   rdy_dly = 0;
   always @(posedge clk) begin
      imem_rd_valid <= imem_rd_req;
      imem_rd_data  <= 32'(decoder_ld_addr >> 2) + 32'(imem_rd_addr);
      tog_prev      <= decoder_ld_req_in;
      if (reset) begin
         imem_block_ready <= 1'b0;
         rdy_dly          <= 0;
         tog_prev         <= 1'b0;
      end else begin
         if (decoder_ld_req_in != tog_prev) rdy_dly <= 3;
         else if (rdy_dly > 1) rdy_dly <= rdy_dly - 1;
         else if (rdy_dly == 1) begin
            rdy_dly          <= 0;
            imem_block_ready <= 1'b1;
         end
         if (imem_rd_block_done) imem_block_ready <= 1'b0;
      end
   end

   logic [DW-1:0] got_d[$];
   bit            got_l[$];
   logic [AW-1:0] ld_a[$];
   logic [MW-1:0] ld_s[$];
   int            n_tog = 0, n_done = 0, n_req = 0;
   logic          mon_tog = 1'b0;
   always @(negedge clk) begin
      if (inst_valid && inst_ready) begin
         got_d.push_back(inst_data);
         got_l.push_back(inst_last);
      end
      if (imem_rd_block_done) n_done++;
      if (imem_rd_req) n_req++;
      if (decoder_ld_req_in != mon_tog) begin
         n_tog++;
         ld_a.push_back(decoder_ld_addr);
         ld_s.push_back(decoder_ld_req_size);
      end
      mon_tog = decoder_ld_req_in;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      if (obs !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      got_d.delete(); got_l.delete(); ld_a.delete(); ld_s.delete();
      n_tog = 0; n_done = 0; n_req = 0;
   endtask

   task automatic do_start(input logic [AW-1:0] base, input logic [31:0] num);
      cfg_base_addr = base;
      cfg_num_inst  = num;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int max);
      int c = 0;
      while (busy && c < max) begin
         tick();
         c++;
      end
      chk({tag, "_done"}, 64'(busy), 64'd0);
   endtask

   task automatic check_stream(input string tag, input logic [AW-1:0] base, input int num);
      int errs = 0;
      chk({tag, "_cnt"}, 64'(got_d.size()), 64'(num));
      for (int k = 0; k < got_d.size(); k++) begin
         if (got_d[k] !== 32'(base >> 2) + 32'(k)) errs++;
         if (got_l[k] !== (k == num - 1)) errs++;
      end
      chk({tag, "_data_last_errs"}, 64'(errs), 64'd0);
   endtask

   task automatic check_reset_outs(input string tag);
      chk({tag, "_rd_req"},  64'(imem_rd_req), 64'd0);
      chk({tag, "_rd_addr"}, 64'(imem_rd_addr), 64'd0);
      chk({tag, "_bdone"},   64'(imem_rd_block_done), 64'd0);
      chk({tag, "_ldaddr"},  64'(decoder_ld_addr), 64'd0);
      chk({tag, "_ldsize"},  64'(decoder_ld_req_size), 64'd0);
      chk({tag, "_ldreq"},   64'(decoder_ld_req_in), 64'd0);
      chk({tag, "_valid"},   64'(inst_valid), 64'd0);
      chk({tag, "_data"},    64'(inst_data), 64'd0);
      chk({tag, "_last"},    64'(inst_last), 64'd0);
      chk({tag, "_busy"},    64'(busy), 64'd0);
   endtask

   initial begin
      repeat (3) tick();
      reset = 1'b0;
      tick();
      check_reset_outs("por");

      // Single short block
      clr();
      do_start(42'h1000, 32'd5);
      wait_idle("t1", 200);
      check_stream("t1", 42'h1000, 5);
      chk("t1_toggles", 64'(n_tog), 64'd1);
      if (n_tog == 1) begin
         chk("t1_ldaddr", 64'(ld_a[0]), 64'h1000);
         chk("t1_ldsize", 64'(ld_s[0]), 64'd20);
      end
      chk("t1_bdone", 64'(n_done), 64'd1);

      // Two blocks: full 1024 then remainder of 6
      clr();
      do_start(42'h1000, 32'd1030);
      wait_idle("t2", 5000);
      check_stream("t2", 42'h1000, 1030);
      chk("t2_toggles", 64'(n_tog), 64'd2);
      if (n_tog == 2) begin
         chk("t2_ldaddr0", 64'(ld_a[0]), 64'h1000);
         chk("t2_ldsize0", 64'(ld_s[0]), 64'd4096);
         chk("t2_ldaddr1", 64'(ld_a[1]), 64'h2000);
         chk("t2_ldsize1", 64'(ld_s[1]), 64'd24);
      end
      chk("t2_bdone", 64'(n_done), 64'd2);

      // Backpressure: credit stops reads at FIFO depth, head holds
      clr();
      inst_ready = 1'b0;
      do_start(42'h200, 32'd8);
      repeat (20) tick();
      chk("t3_reads_stalled", 64'(n_req), 64'd4);
      chk("t3_hold_valid", 64'(inst_valid), 64'd1);
      chk("t3_hold_data", 64'(inst_data), 64'h80);
      inst_ready = 1'b1;
      wait_idle("t3", 200);
      check_stream("t3", 42'h200, 8);
      chk("t3_reads_total", 64'(n_req), 64'd8);

      // Ignored starts: zero length, and start while busy
      clr();
      do_start(42'h3000, 32'd0);
      repeat (6) tick();
      chk("t4_zero_busy", 64'(busy), 64'd0);
      chk("t4_zero_tog", 64'(n_tog), 64'd0);
      do_start(42'h1000, 32'd5);
      tick();
      do_start(42'h5000, 32'd7);
      wait_idle("t4", 200);
      check_stream("t4", 42'h1000, 5);
      chk("t4_busy_tog", 64'(n_tog), 64'd1);

      // Reset mid-FETCH, then a fresh short program
      clr();
      do_start(42'h4000, 32'd50);
      begin
         int c = 0;
         while (!imem_rd_req && c < 50) begin
            tick();
            c++;
         end
         chk("t5_reach_fetch", 64'(imem_rd_req), 64'd1);
      end
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_reset_outs("t5_rst");
      tick();
      chk("t5_inflight_dropped", 64'(inst_valid), 64'd0);
      clr();
      do_start(42'h8000, 32'd3);
      wait_idle("t5", 200);
      check_stream("t5", 42'h8000, 3);
      chk("t5_toggles", 64'(n_tog), 64'd1);
      if (n_tog == 1) begin
         chk("t5_ldaddr", 64'(ld_a[0]), 64'h8000);
         chk("t5_ldsize", 64'(ld_s[0]), 64'd12);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit
Interface
REQ-001 SHALL have parameter INST_DATA_WIDTH, default 32, instruction width in bits.
REQ-002 SHALL have parameter INST_ADDR_WIDTH, default 10; block capacity BLOCK_INST = 2^INST_ADDR_WIDTH instructions.
REQ-003 SHALL have parameter AXI_ADDR_WIDTH, default 42, DDR byte-address width.
REQ-004 SHALL have parameter MEM_REQ_W, default 16, load-size width in bytes.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, output instruction FIFO depth (power of two, >=2).
REQ-006 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-007 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port start  input  1  one-cycle program-fetch start pulse.
REQ-009 SHALL have port cfg_base_addr  input  AXI_ADDR_WIDTH  program byte address in DDR, sampled on start.
REQ-010 SHALL have port cfg_num_inst  input  32  program length in instructions, sampled on start.
REQ-011 SHALL have port imem_block_ready  input  1  instruction memory holds a complete block.
REQ-012 SHALL have port imem_rd_req  output  1  instruction-memory read strobe.
REQ-013 SHALL have port imem_rd_addr  output  INST_ADDR_WIDTH  read address within block.
REQ-014 SHALL have port imem_rd_valid  input  1  read data valid, exactly one cycle after imem_rd_req.
REQ-015 SHALL have port imem_rd_data  input  INST_DATA_WIDTH  read data.
REQ-016 SHALL have port imem_rd_block_done  output  1  one-cycle pulse, current block fully consumed.
REQ-017 SHALL have port decoder_ld_addr  output  AXI_ADDR_WIDTH  DDR byte address of next block load.
REQ-018 SHALL have port decoder_ld_req_size  output  MEM_REQ_W  next block load size in bytes.
REQ-019 SHALL have port decoder_ld_req_in  output  1  load request encoded as level toggle; each toggle = one request.
REQ-020 SHALL have port inst_valid  output  1  instruction available to decoder.
REQ-021 SHALL have port inst_ready  input  1  decoder accepts; transfer when inst_valid & inst_ready.
REQ-022 SHALL have port inst_data  output  INST_DATA_WIDTH  instruction word.
REQ-023 SHALL have port inst_last  output  1  qualifies final instruction of program.
REQ-024 SHALL have port busy  output  1  high from accepted start until last instruction transferred.
Function
REQ-025 SHALL implement FSM states IDLE, REQ, WAIT, FETCH, DRAIN.
REQ-026 IDLE: start with cfg_num_inst>0 latches cur_addr=cfg_base_addr, remaining=cfg_num_inst, goes REQ; start with cfg_num_inst=0 is ignored; start outside IDLE is ignored.
REQ-027 REQ (one cycle): blk_n=min(remaining,BLOCK_INST); registers decoder_ld_addr=cur_addr, decoder_ld_req_size=blk_n*INST_DATA_WIDTH/8, toggles decoder_ld_req_in same edge (addr/size stable before and while toggle is seen); goes WAIT.
REQ-028 WAIT: goes FETCH only on imem_block_ready rising edge (low previous cycle, high now); read index resets to 0.
REQ-029 FETCH: imem_rd_req asserted with imem_rd_addr=index when issued<blk_n and fifo_count+outstanding<FIFO_DEPTH; index increments per request.
REQ-030 Each imem_rd_valid pushes imem_rd_data into FIFO; outstanding SHALL never exceed 1 read in flight beyond credit, FIFO SHALL never overflow.
REQ-031 When all blk_n reads returned: imem_rd_block_done pulses one cycle; cur_addr+=blk_n*INST_DATA_WIDTH/8 (modulo 2^AXI_ADDR_WIDTH); remaining-=blk_n; goes REQ if remaining>0 else DRAIN.
REQ-032 DRAIN: goes IDLE when FIFO empty after final transfer; busy falls same edge.
REQ-033 FIFO: simultaneous push and pop allowed at any occupancy including full and empty (empty: bypass not required, data appears next cycle); inst_valid = FIFO non-empty.
REQ-034 inst_last SHALL be high only with the instruction whose global index equals cfg_num_inst-1.
REQ-035 inst_data/inst_valid SHALL hold stable while inst_valid & ~inst_ready.
Reset
REQ-036 reset SHALL force IDLE, empty FIFO, counters 0, and outputs imem_rd_req=0, imem_rd_addr=0, imem_rd_block_done=0, decoder_ld_addr=0, decoder_ld_req_size=0, decoder_ld_req_in=0, inst_valid=0, inst_data=0, inst_last=0, busy=0.
REQ-037 reset mid-operation SHALL abandon the program; in-flight imem_rd_valid in the following cycle SHALL be discarded.
Structure
REQ-038 FSM state encoding and BLOCK_INST/bytes-per-instruction constants SHALL reside in shared package genesys_imem_pkg.
REQ-039 Output FIFO SHALL be one sub-module, fetch_inst_fifo (data+last, count output).
Verification
REQ-040 num=5, base=0x1000, inst_ready=1 -> one toggle, addr 0x1000, size 20, 5 instructions in order, inst_last on 5th, one block_done pulse.
REQ-041 num=1030, INST_ADDR_WIDTH=10 -> requests size 4096 @0x1000 then size 24 @0x2000, two block_done pulses, 1030 instructions.
REQ-042 FIFO_DEPTH=4, inst_ready low 20 cycles -> exactly 4 reads issued, no loss or duplication after release.
REQ-043 start with num=0, and start while busy -> no toggle, no state change.
REQ-044 reset asserted in FETCH -> all outputs at reset values next cycle; subsequent start num=3 completes correctly.
